// File: rtl/traffic_timer_pkg.sv
// Shared constants and width helper for the intersection timing blocks.
package traffic_timer_pkg;

   localparam int CLK_HZ          = 50_000_000;
   localparam int YELLOW_SECS_DEF = 3;
   localparam int GREEN_SECS_DEF  = 10;
   localparam int DELAY_SECS_DEF  = 5;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// One timing channel: a seconds prescaler feeding a saturating seconds
// counter. done is a registered level that rises on the edge completing
// TARGET*TICK_DIV enabled cycles after clr, and holds until clr or reset.
module interval_timer
   import traffic_timer_pkg::*;
#(
   parameter int TICK_DIV = CLK_HZ,
   parameter int TARGET   = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic done
);

   localparam int PW = cnt_width(TICK_DIV);
   localparam int SW = cnt_width(TARGET + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SECS_LAST = SW'(TARGET - 1);

   generate
      if (TICK_DIV < 1) begin : g_bad_div
         $fatal(1, "interval_timer: TICK_DIV must be >= 1");
      end
      if (TARGET < 1) begin : g_bad_target
         $fatal(1, "interval_timer: TARGET must be >= 1");
      end
   endgenerate

   logic [PW-1:0] pre;
   logic [SW-1:0] secs;

   // Clear beats advance; once done the channel ignores en so secs never
   // runs past TARGET. With TICK_DIV == 1 pre stays at 0 and every enabled
   // cycle is a whole second.
   always_ff @(posedge clock) begin
      if (reset) begin
         pre  <= '0;
         secs <= '0;
         done <= 1'b0;
      end else if (clr) begin
         pre  <= '0;
         secs <= '0;
         done <= 1'b0;
      end else if (en && !done) begin
         if (pre == PRE_LAST) begin
            pre  <= '0;
            secs <= secs + SW'(1);
            if (secs == SECS_LAST) begin
               done <= 1'b1;
            end
         end else begin
            pre <= pre + PW'(1);
         end
      end
   end

endmodule

// File: rtl/light_timer_unit.sv
// Timing responder for the intersection controller: three independent
// interval channels (yellow, green/ped max, five-second delay) whose
// registered completion levels are returned to the controller FSM.
module light_timer_unit
   import traffic_timer_pkg::*;
#(
   parameter int TICK_DIV    = CLK_HZ,
   parameter int YELLOW_SECS = YELLOW_SECS_DEF,
   parameter int GREEN_SECS  = GREEN_SECS_DEF,
   parameter int DELAY_SECS  = DELAY_SECS_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic yellow_en,
   input  logic yellow_clr,
   input  logic stop_en,
   input  logic stop_clr,
   input  logic five_en,
   input  logic five_clr,
   output logic stop_yellow,
   output logic stop_ped,
   output logic stop_five
);

   generate
      if (TICK_DIV < 1 || YELLOW_SECS < 1 || GREEN_SECS < 1 || DELAY_SECS < 1) begin : g_bad_param
         $fatal(1, "light_timer_unit: TICK_DIV and all *_SECS must be >= 1");
      end
   endgenerate

   interval_timer #(.TICK_DIV(TICK_DIV), .TARGET(YELLOW_SECS)) u_yellow (
      .clock (clock),
      .reset (reset),
      .en    (yellow_en),
      .clr   (yellow_clr),
      .done  (stop_yellow)
   );

   interval_timer #(.TICK_DIV(TICK_DIV), .TARGET(GREEN_SECS)) u_green (
      .clock (clock),
      .reset (reset),
      .en    (stop_en),
      .clr   (stop_clr),
      .done  (stop_ped)
   );

   interval_timer #(.TICK_DIV(TICK_DIV), .TARGET(DELAY_SECS)) u_delay (
      .clock (clock),
      .reset (reset),
      .en    (five_en),
      .clr   (five_clr),
      .done  (stop_five)
   );

endmodule

// File: tb/tb_light_timer_unit.sv
// Bench for light_timer_unit: two instances (TICK_DIV=4 and TICK_DIV=1)
// driven by the same directed and random stimulus, checked every cycle
// against a count-of-enabled-cycles reference model.
module tb_light_timer_unit;

   localparam int TD  = 4;
   localparam int YS  = 3;
   localparam int GS  = 10;
   localparam int DS  = 5;
   localparam int TD2 = 1;
   localparam int YS2 = 1;
   localparam int GS2 = 2;
   localparam int DS2 = 3;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [2:0] en_v;   // {five, stop, yellow}
   logic [2:0] clr_v;
   logic a_yel, a_ped, a_five;
   logic b_yel, b_ped, b_five;

   light_timer_unit #(.TICK_DIV(TD), .YELLOW_SECS(YS), .GREEN_SECS(GS), .DELAY_SECS(DS)) dut_a (
      .clock       (clock),
      .reset       (reset),
      .yellow_en   (en_v[0]),
      .yellow_clr  (clr_v[0]),
      .stop_en     (en_v[1]),
      .stop_clr    (clr_v[1]),
      .five_en     (en_v[2]),
      .five_clr    (clr_v[2]),
      .stop_yellow (a_yel),
      .stop_ped    (a_ped),
      .stop_five   (a_five)
   );

   light_timer_unit #(.TICK_DIV(TD2), .YELLOW_SECS(YS2), .GREEN_SECS(GS2), .DELAY_SECS(DS2)) dut_b (
      .clock       (clock),
      .reset       (reset),
      .yellow_en   (en_v[0]),
      .yellow_clr  (clr_v[0]),
      .stop_en     (en_v[1]),
      .stop_clr    (clr_v[1]),
      .five_en     (en_v[2]),
      .five_clr    (clr_v[2]),
      .stop_yellow (b_yel),
      .stop_ped    (b_ped),
      .stop_five   (b_five)
   );

   // ---------------- scoreboard ----------------
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [5:0]  exp_q[$];
   int          cnt[6];
   int          lim[6];

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Reference: each channel's stop is high once it has seen N enabled
   // cycles since its last clear or reset, N = SECS*TICK_DIV.
   function automatic void model_edge();
      logic [5:0] e;
      for (int c = 0; c < 6; c++) begin
         if (reset || clr_v[c % 3]) cnt[c] = 0;
         else if (en_v[c % 3] && cnt[c] < lim[c]) cnt[c] = cnt[c] + 1;
         e[c] = (cnt[c] >= lim[c]);
      end
      exp_q.push_back(e);
   endfunction

   function automatic logic [5:0] outs();
      return {b_five, b_ped, b_yel, a_five, a_ped, a_yel};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [2:0] en, input logic [2:0] clr, input logic rst);
      en_v  = en;
      clr_v = clr;
      reset = rst;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
      check("outs", outs(), exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      lim = '{YS*TD, GS*TD, DS*TD, YS2*TD2, GS2*TD2, DS2*TD2};
      for (int c = 0; c < 6; c++) cnt[c] = 0;
      set_in(3'b000, 3'b000, 1'b1);
      #1;
      cycle();
      cycle();
      check("reset_outs", outs(), 6'd0);

      // 1: yellow from clear, held en, saturates
      set_in(3'b000, 3'b001, 1'b0);
      cycle();
      for (int i = 1; i <= 32; i++) begin
         set_in(3'b001, 3'b000, 1'b0);
         cycle();
         if (i == 11) check("t1_yel_low_11", a_yel, 1'b0);
         if (i == 12) check("t1_yel_high_12", a_yel, 1'b1);
      end
      check("t1_yel_held", a_yel, 1'b1);

      // 2: green with a pause
      set_in(3'b000, 3'b010, 1'b0);
      cycle();
      for (int i = 1; i <= 17; i++) begin set_in(3'b010, 3'b000, 1'b0); cycle(); end
      for (int i = 1; i <= 9; i++) begin set_in(3'b000, 3'b000, 1'b0); cycle(); end
      check("t2_paused_low", a_ped, 1'b0);
      for (int i = 1; i <= 23; i++) begin
         set_in(3'b010, 3'b000, 1'b0);
         cycle();
         if (i == 22) check("t2_ped_low_39", a_ped, 1'b0);
         if (i == 23) check("t2_ped_high_40", a_ped, 1'b1);
      end

      // 3: clr and en together restart the delay channel
      set_in(3'b000, 3'b100, 1'b0);
      cycle();
      for (int i = 1; i <= 19; i++) begin set_in(3'b100, 3'b000, 1'b0); cycle(); end
      set_in(3'b100, 3'b100, 1'b0);
      cycle();
      check("t3_clr_wins", a_five, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         set_in(3'b100, 3'b000, 1'b0);
         cycle();
         if (i == 19) check("t3_five_low_19", a_five, 1'b0);
         if (i == 20) check("t3_five_high_20", a_five, 1'b1);
      end

      // 4: all channels together, then clear yellow only
      set_in(3'b000, 3'b111, 1'b0);
      cycle();
      for (int i = 1; i <= 40; i++) begin
         set_in(3'b111, 3'b000, 1'b0);
         cycle();
         if (i == 12) check("t4_at12", {a_five, a_ped, a_yel}, 6'b000_001);
         if (i == 20) check("t4_at20", {a_five, a_ped, a_yel}, 6'b000_101);
         if (i == 40) check("t4_at40", {a_five, a_ped, a_yel}, 6'b000_111);
      end
      set_in(3'b111, 3'b001, 1'b0);
      cycle();
      check("t4_yel_clr_only", {a_five, a_ped, a_yel}, 6'b000_110);

      // 5: reset mid-interval
      set_in(3'b000, 3'b010, 1'b0);
      cycle();
      for (int i = 1; i <= 30; i++) begin set_in(3'b010, 3'b000, 1'b0); cycle(); end
      set_in(3'b000, 3'b000, 1'b1);
      cycle();
      check("t5_reset_all0", outs(), 6'd0);
      for (int i = 1; i <= 40; i++) begin
         set_in(3'b010, 3'b000, 1'b0);
         cycle();
         if (i == 39) check("t5_ped_low_39", a_ped, 1'b0);
         if (i == 40) check("t5_ped_high_40", a_ped, 1'b1);
      end

      // 6: single-cycle seconds instance
      set_in(3'b000, 3'b111, 1'b0);
      cycle();
      set_in(3'b001, 3'b000, 1'b0);
      cycle();
      check("t6_div1_yel", {b_yel, a_yel}, 6'b000_010);

      // random traffic on all channels
      for (int i = 0; i < 400; i++) begin
         logic [2:0] e, c;
         for (int k = 0; k < 3; k++) begin
            e[k] = ($urandom_range(0, 3) != 0);
            c[k] = ($urandom_range(0, 40) == 0);
         end
         set_in(e, c, ($urandom_range(0, 150) == 0));
         cycle();
      end

      check("q_drained", 6'(exp_q.size()), 6'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
